// File: rtl/fir_meter_pkg.sv
// fir_meter_pkg: shared FSM state type and rounding constants for the FIR peak meter
package fir_meter_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, FLUSH, DONE} state_t;
    localparam int ROUND_BIAS = 2 ** 14;
    localparam int Q15_MAX    = 2 ** 15 - 1;
endpackage

// File: rtl/lane_abs_max.sv
// lane_abs_max: combinational saturating |y| per lane followed by an unsigned max over lanes
//  y  in  L x IN_WIDTH  signed lanes
//  m  out IN_WIDTH-1    largest magnitude; the most negative input maps to 2^(IN_WIDTH-1)-1
module lane_abs_max #(
    parameter int L        = 3,
    parameter int IN_WIDTH = 40
) (
    input  logic [L-1:0][IN_WIDTH-1:0] y,
    output logic [IN_WIDTH-2:0]        m
);
    logic [L-1:0][IN_WIDTH-2:0] a;

    genvar i;
    for (i = 0; i < L; i++) begin : g_abs
        logic [IN_WIDTH-1:0] n;
        assign n = -y[i];
        // Only the most negative value negates to itself (sign still set), so that is the saturation case.
        assign a[i] = !y[i][IN_WIDTH-1] ? y[i][IN_WIDTH-2:0] : n[IN_WIDTH-1] ? '1 : n[IN_WIDTH-2:0];
    end

    always_comb begin
        m = '0;
        for (int k = 0; k < L; k++) m = a[k] > m ? a[k] : m;
    end
endmodule

// File: rtl/fir_peak_meter.sv
// fir_peak_meter: windowed peak |y| meter over the parallel FIR output lanes
//  clk, rst_n      clock and synchronous active-low reset
//  start           begin a measurement (accepted only in IDLE)
//  settle_cycles   cycles ignored after start, latched on start
//  window_cycles   cycles measured, latched on start, 0 acts as 1
//  y               L signed lanes, Q10.30
//  busy            high while settling, measuring or flushing
//  peak            raw unsigned peak magnitude, Q9.30
//  peak_q15        peak rounded half-up to Q1.15 and saturated
//  peak_valid      one-cycle pulse once the results are final
//  sat_seen        a measured magnitude reached 1.0
module fir_peak_meter import fir_meter_pkg::*; #(
    parameter int L         = 3,
    parameter int IN_WIDTH  = 40,
    parameter int FRAC_IN   = 30,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_WIDTH-1:0]       settle_cycles,
    input  logic [CNT_WIDTH-1:0]       window_cycles,
    input  logic [L-1:0][IN_WIDTH-1:0] y,
    output logic                       busy,
    output logic [IN_WIDTH-2:0]        peak,
    output logic [OUT_WIDTH-1:0]       peak_q15,
    output logic                       peak_valid,
    output logic                       sat_seen
);
    localparam logic [IN_WIDTH-1:0]         BIAS = IN_WIDTH'(ROUND_BIAS);
    localparam logic [IN_WIDTH-OUT_WIDTH:0] QMAX = (IN_WIDTH - OUT_WIDTH + 1)'(Q15_MAX);
    localparam logic [IN_WIDTH-2:0]         ONE  = {{(IN_WIDTH - 2 - FRAC_IN){1'b0}}, 1'b1, {FRAC_IN{1'b0}}};

    state_t                  state;
    logic [CNT_WIDTH-1:0]    cnt, win_m1;
    logic [IN_WIDTH-2:0]     m_c, m_r;
    logic [IN_WIDTH-1:0]     rnd;
    logic [IN_WIDTH-OUT_WIDTH:0] q;

    lane_abs_max #(.L(L), .IN_WIDTH(IN_WIDTH)) u_abs (.y(y), .m(m_c));

    assign rnd = {1'b0, peak} + BIAS;
    assign q   = rnd[IN_WIDTH-1:OUT_WIDTH-1];

    // SETTLE is left one edge after its count expires so that MEASURE folds exactly the
    // m_r values captured from the window samples (m_r lags y by one edge).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            win_m1     <= '0;
            m_r        <= '0;
            busy       <= 1'b0;
            peak       <= '0;
            peak_q15   <= '0;
            peak_valid <= 1'b0;
            sat_seen   <= 1'b0;
        end else begin
            m_r        <= m_c;
            peak_valid <= state == DONE;
            case (state)
                IDLE: if (start) begin
                    state    <= SETTLE;
                    cnt      <= settle_cycles;
                    win_m1   <= window_cycles == '0 ? '0 : window_cycles - 1'b1;
                    busy     <= 1'b1;
                    peak     <= '0;
                    sat_seen <= 1'b0;
                end
                SETTLE: begin
                    state <= cnt == '0 ? MEASURE : SETTLE;
                    cnt   <= cnt == '0 ? win_m1 : cnt - 1'b1;
                end
                MEASURE: begin
                    peak     <= m_r > peak ? m_r : peak;
                    sat_seen <= sat_seen | (m_r >= ONE);
                    state    <= cnt == '0 ? FLUSH : MEASURE;
                    cnt      <= cnt == '0 ? cnt : cnt - 1'b1;
                end
                FLUSH: begin
                    peak_q15 <= q > QMAX ? OUT_WIDTH'(Q15_MAX) : q[OUT_WIDTH-1:0];
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_peak_meter.sv
// tb_fir_peak_meter: scoreboard bench for fir_peak_meter timing, rounding, saturation and abort
module tb_fir_peak_meter;
    typedef struct packed {
        logic [38:0] peak;
        logic [15:0] q15;
        logic        sat;
        int          vedge;
    } exp_t;

    localparam logic signed [40:0] MAXM = (41'sd1 <<< 39) - 41'sd1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       settle_cycles = '0;
    logic [15:0]       window_cycles = '0;
    logic [2:0][39:0]  y = '0;
    logic              busy, peak_valid, sat_seen;
    logic [38:0]       peak;
    logic [15:0]       peak_q15;

    logic [2:0][39:0]  base_y = '0;
    logic [2:0][39:0]  pulse_y = '0;
    int                pulse_at = -1;
    int                n_chk = 0;
    int                n_fail = 0;
    exp_t              sb[$];

    fir_peak_meter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .settle_cycles(settle_cycles),
        .window_cycles(window_cycles), .y(y), .busy(busy), .peak(peak),
        .peak_q15(peak_q15), .peak_valid(peak_valid), .sat_seen(sat_seen)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0][39:0] y_at(input int k);
        return k == pulse_at ? pulse_y : base_y;
    endfunction

    function automatic logic [38:0] mag(input logic [39:0] v);
        logic signed [40:0] s;
        s = {v[39], v};
        if (s < 0) s = -s;
        if (s > MAXM) s = MAXM;
        return s[38:0];
    endfunction

    task automatic push_model(input int s, input int w);
        exp_t e;
        int we;
        logic [2:0][39:0] v;
        logic [38:0] m;
        longint r;
        we = w == 0 ? 1 : w;
        e = '0;
        for (int k = s + 1; k <= s + we; k++) begin
            v = y_at(k);
            for (int l = 0; l < 3; l++) begin
                m = mag(v[l]);
                if (m > e.peak) e.peak = m;
                if (m >= 39'h40000000) e.sat = 1'b1;
            end
        end
        r = (longint'(e.peak) + 16384) >> 15;
        e.q15 = r > 32767 ? 16'd32767 : r[15:0];
        e.vedge = s + we + 3;
        sb.push_back(e);
    endtask

    task automatic run(input int s, input int w, input int restart_at, input string nm);
        exp_t e;
        int n;
        int extra;
        push_model(s, w);
        @(negedge clk);
        settle_cycles = 16'(s);
        window_cycles = 16'(w);
        y = y_at(0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        y = y_at(1);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                n_chk++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start got=%b want=1", nm, busy); end
            end
            if (peak_valid) break;
            start = n == restart_at;
            if (n == restart_at) begin
                settle_cycles = 16'd50;
                window_cycles = 16'd50;
            end
            y = y_at(n + 1);
        end
        start = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if (n !== e.vedge) begin n_fail++; $display("FAIL %s valid_edge got=%0d want=%0d", nm, n, e.vedge); end
        n_chk++;
        if (peak !== e.peak) begin n_fail++; $display("FAIL %s peak got=%h want=%h", nm, peak, e.peak); end
        n_chk++;
        if (peak_q15 !== e.q15) begin n_fail++; $display("FAIL %s peak_q15 got=%0d want=%0d", nm, peak_q15, e.q15); end
        n_chk++;
        if (sat_seen !== e.sat) begin n_fail++; $display("FAIL %s sat_seen got=%b want=%b", nm, sat_seen, e.sat); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_valid got=%b want=0", nm, busy); end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (peak_valid) extra++;
        end
        n_chk++;
        if (extra !== 0) begin n_fail++; $display("FAIL %s extra_valid got=%0d want=0", nm, extra); end
        n_chk++;
        if (peak !== e.peak) begin n_fail++; $display("FAIL %s peak_hold got=%h want=%h", nm, peak, e.peak); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, peak, peak_q15, peak_valid, sat_seen} !== '0)
            begin n_fail++; $display("FAIL reset outputs got=%b/%h/%0d/%b/%b want=all zero", busy, peak, peak_q15, peak_valid, sat_seen); end
        rst_n = 1'b1;
    endtask

    task automatic test_half_scale;
        base_y = {3{40'sd1 <<< 29}};
        pulse_at = -1;
        run(2, 4, 0, "half_scale");
    endtask

    task automatic test_saturate;
        base_y = {40'd5, 40'd0, 40'h80_0000_0000};
        pulse_at = -1;
        run(0, 1, 0, "saturate");
    endtask

    task automatic test_pulse;
        base_y = '0;
        pulse_y = {40'd3 << 28, 40'd0, 40'd0};
        pulse_at = 4;
        run(2, 4, 0, "pulse_mid");
        pulse_at = 2;
        run(2, 4, 0, "pulse_before");
        pulse_at = 7;
        run(2, 4, 0, "pulse_after");
        pulse_at = -1;
    endtask

    task automatic test_zero_window;
        base_y = {3{40'd1 << 15}};
        pulse_at = -1;
        run(1, 0, 0, "zero_window");
    endtask

    task automatic test_back_to_back;
        base_y = {40'd7, 40'hFF_FFFF_0000, 40'd12345};
        pulse_at = -1;
        run(3, 5, 5, "restart_ignored");
        run(0, 3, 0, "back_to_back");
    endtask

    task automatic test_abort;
        int extra;
        base_y = {3{40'd1 << 29}};
        pulse_at = -1;
        @(negedge clk);
        settle_cycles = 16'd1;
        window_cycles = 16'd10;
        y = base_y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_chk++;
        if ({busy, peak, peak_q15, sat_seen} !== '0)
            begin n_fail++; $display("FAIL abort outputs got=%b/%h/%0d/%b want=all zero", busy, peak, peak_q15, sat_seen); end
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (peak_valid) extra++;
        end
        n_chk++;
        if (extra !== 0) begin n_fail++; $display("FAIL abort no_valid got=%0d want=0", extra); end
        run(1, 2, 0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_half_scale();
        test_saturate();
        test_pulse();
        test_zero_window();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
